// File: rtl/rx_sync_ctrl.sv
// rx_sync_ctrl: symbol sync acquisition/loss tracking for the 10b-to-8b decode
// path, gating decoder output into a registered byte stream.
module rx_sync_ctrl #(
  parameter int unsigned COMMAS_TO_SYNC  = 3,
  parameter int unsigned ERRS_TO_LOS     = 4,
  parameter int unsigned GOOD_TO_RECOVER = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic [9:0] data10_in,
  input  logic [7:0] data8_in,
  input  logic       k_in,
  input  logic       code_err_in,
  output logic [7:0] data8_out,
  output logic       k_out,
  output logic       valid_out,
  output logic       comma_det,
  output logic       sync_ok,
  output logic [1:0] state_out
);

  localparam int unsigned CNT_W = 3;
  localparam logic [9:0] K28_5_RDN = 10'h17C;
  localparam logic [9:0] K28_5_RDP = 10'h283;

  typedef enum logic [1:0] {
    ST_LOS   = 2'd0,
    ST_ACQ   = 2'd1,
    ST_SYNC  = 2'd2,
    ST_CHECK = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   comma_cnt_q, comma_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   good_cnt_q, good_cnt_d;
  logic [7:0]         data8_d;
  logic               k_d;
  logic               valid_d;
  logic               comma_det_d;
  logic               is_comma;
  logic [CNT_W-1:0]   inc_cnt;
  logic [CNT_W-1:0]   dec_cnt;

  // Saturating increment shared by all symbol counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == {CNT_W{1'b1}}) ? x : x + CNT_W'(1);
  endfunction

  // A coding error disqualifies a symbol from being a comma.
  assign is_comma = !code_err_in &&
                    ((data10_in == K28_5_RDN) || (data10_in == K28_5_RDP));

  // State, counters and forwarded outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_LOS;
      comma_cnt_q <= '0;
      err_cnt_q   <= '0;
      good_cnt_q  <= '0;
      data8_out   <= 8'h00;
      k_out       <= 1'b0;
      valid_out   <= 1'b0;
      comma_det   <= 1'b0;
    end else begin
      state_q     <= state_d;
      comma_cnt_q <= comma_cnt_d;
      err_cnt_q   <= err_cnt_d;
      good_cnt_q  <= good_cnt_d;
      data8_out   <= data8_d;
      k_out       <= k_d;
      valid_out   <= valid_d;
      comma_det   <= comma_det_d;
    end
  end

  // Next-state, counter and forwarding decisions; forwarding uses pre-update state.
  always_comb begin
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    err_cnt_d   = err_cnt_q;
    good_cnt_d  = good_cnt_q;
    data8_d     = data8_out;
    k_d         = k_out;
    valid_d     = 1'b0;
    comma_det_d = 1'b0;
    inc_cnt     = '0;
    dec_cnt     = '0;

    if (enb) begin
      comma_det_d = is_comma;

      if (((state_q == ST_SYNC) || (state_q == ST_CHECK)) && !code_err_in) begin
        valid_d = 1'b1;
        data8_d = data8_in;
        k_d     = k_in | is_comma;
      end

      case (state_q)
        ST_LOS: begin
          if (is_comma) begin
            comma_cnt_d = CNT_W'(1);
            state_d     = (COMMAS_TO_SYNC == 1) ? ST_SYNC : ST_ACQ;
          end else begin
            comma_cnt_d = '0;
          end
        end
        ST_ACQ: begin
          if (code_err_in) begin
            state_d     = ST_LOS;
            comma_cnt_d = '0;
          end else if (is_comma) begin
            inc_cnt = sat_inc(comma_cnt_q);
            if (inc_cnt >= CNT_W'(COMMAS_TO_SYNC)) begin
              state_d     = ST_SYNC;
              comma_cnt_d = '0;
            end else begin
              comma_cnt_d = inc_cnt;
            end
          end
        end
        ST_SYNC: begin
          if (code_err_in) begin
            state_d    = ST_CHECK;
            err_cnt_d  = CNT_W'(1);
            good_cnt_d = '0;
          end
        end
        ST_CHECK: begin
          if (code_err_in) begin
            inc_cnt    = sat_inc(err_cnt_q);
            good_cnt_d = '0;
            if (inc_cnt == CNT_W'(ERRS_TO_LOS)) begin
              state_d     = ST_LOS;
              comma_cnt_d = '0;
              err_cnt_d   = '0;
            end else begin
              err_cnt_d = inc_cnt;
            end
          end else begin
            inc_cnt = sat_inc(good_cnt_q);
            if (inc_cnt == CNT_W'(GOOD_TO_RECOVER)) begin
              dec_cnt    = err_cnt_q - CNT_W'(1);
              err_cnt_d  = dec_cnt;
              good_cnt_d = '0;
              if (dec_cnt == '0) begin
                state_d = ST_SYNC;
              end
            end else begin
              good_cnt_d = inc_cnt;
            end
          end
        end
        default: state_d = ST_LOS;
      endcase
    end
  end

  // Status is a direct decode of the state register.
  assign state_out = state_q;
  assign sync_ok   = state_q[1];

endmodule

// File: tb/tb_rx_sync_ctrl.sv
// Self-checking bench for rx_sync_ctrl: directed scenarios plus random symbols
// compared every cycle against a behavioural model.
module tb_rx_sync_ctrl;

  localparam int C_SYNC = 3;
  localparam int E_LOS  = 4;
  localparam int G_REC  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       enb;
  logic [9:0] data10_in;
  logic [7:0] data8_in;
  logic       k_in;
  logic       code_err_in;
  logic [7:0] data8_out;
  logic       k_out;
  logic       valid_out;
  logic       comma_det;
  logic       sync_ok;
  logic [1:0] state_out;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int         m_state, m_commas, m_errs, m_goods;
  logic [7:0] m_d8;
  logic       m_k, m_v, m_cd;

  rx_sync_ctrl #(
    .COMMAS_TO_SYNC (C_SYNC),
    .ERRS_TO_LOS    (E_LOS),
    .GOOD_TO_RECOVER(G_REC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enb        (enb),
    .data10_in  (data10_in),
    .data8_in   (data8_in),
    .k_in       (k_in),
    .code_err_in(code_err_in),
    .data8_out  (data8_out),
    .k_out      (k_out),
    .valid_out  (valid_out),
    .comma_det  (comma_det),
    .sync_ok    (sync_ok),
    .state_out  (state_out)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0; m_commas = 0; m_errs = 0; m_goods = 0;
    m_d8 = 8'h00; m_k = 1'b0; m_v = 1'b0; m_cd = 1'b0;
  endtask

  // One symbol worth of the rules: 0=LOS 1=ACQ 2=SYNC 3=CHECK.
  task automatic model_step(input logic en, input logic [9:0] d10, input logic [7:0] d8,
                            input logic k, input logic err);
    bit comma;
    m_v  = 1'b0;
    m_cd = 1'b0;
    if (!en) return;
    comma = !err && (d10 == 10'h17C || d10 == 10'h283);
    m_cd  = comma;
    if (m_state >= 2 && !err) begin
      m_v = 1'b1; m_d8 = d8; m_k = k | comma;
    end
    if (m_state == 0) begin
      if (comma) begin
        m_commas = 1;
        m_state  = (C_SYNC == 1) ? 2 : 1;
      end else m_commas = 0;
    end else if (m_state == 1) begin
      if (err) begin
        m_state = 0; m_commas = 0;
      end else if (comma) begin
        m_commas = (m_commas < 7) ? m_commas + 1 : 7;
        if (m_commas >= C_SYNC) begin m_state = 2; m_commas = 0; end
      end
    end else if (m_state == 2) begin
      if (err) begin m_state = 3; m_errs = 1; m_goods = 0; end
    end else begin
      if (err) begin
        m_goods = 0;
        m_errs  = (m_errs < 7) ? m_errs + 1 : 7;
        if (m_errs == E_LOS) begin m_state = 0; m_errs = 0; m_commas = 0; end
      end else begin
        m_goods++;
        if (m_goods == G_REC) begin
          m_goods = 0;
          m_errs--;
          if (m_errs == 0) m_state = 2;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model.
  task automatic check_all();
    chk("state_out", 32'(state_out), 32'(m_state));
    chk("sync_ok",   32'(sync_ok),   32'(m_state >= 2));
    chk("valid_out", 32'(valid_out), 32'(m_v));
    chk("comma_det", 32'(comma_det), 32'(m_cd));
    chk("data8_out", 32'(data8_out), 32'(m_d8));
    chk("k_out",     32'(k_out),     32'(m_k));
  endtask

  // Drive one cycle; inputs change 1 time unit after the edge, outputs checked 1 after.
  task automatic step(input logic en, input logic [9:0] d10, input logic [7:0] d8,
                      input logic k, input logic err);
    enb = en; data10_in = d10; data8_in = d8; k_in = k; code_err_in = err;
    @(posedge clk);
    model_step(en, d10, d8, k, err);
    #1;
    check_all();
  endtask

  task automatic comma_sym(input logic [9:0] d10);
    step(1'b1, d10, 8'hBC, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    #2 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    enb = 1'b1; data10_in = 10'h17C; data8_in = 8'hBC; k_in = 1'b1; code_err_in = 1'b0;
    model_reset();

    // Reset held low with random inputs
    for (int i = 0; i < 3; i++) begin
      enb = 1'($urandom); data10_in = 10'($urandom); data8_in = 8'($urandom);
      k_in = 1'($urandom); code_err_in = 1'($urandom);
      @(posedge clk); #1;
      check_all();
    end
    rst = 1'b1;

    // Priority: errored comma in LOS is not a comma
    step(1'b1, 10'h17C, 8'hBC, 1'b1, 1'b1);
    chk("prio_comma_det", 32'(comma_det), 32'd0);
    chk("prio_state", 32'(state_out), 32'd0);

    // Acquisition
    comma_sym(10'h17C);
    chk("acq1_state", 32'(state_out), 32'd1);
    chk("acq1_comma_det", 32'(comma_det), 32'd1);
    comma_sym(10'h283);
    chk("acq2_state", 32'(state_out), 32'd1);
    comma_sym(10'h17C);
    chk("acq3_state", 32'(state_out), 32'd2);
    chk("acq3_sync_ok", 32'(sync_ok), 32'd1);
    chk("acq3_valid", 32'(valid_out), 32'd0);
    step(1'b1, 10'h274, 8'h00, 1'b0, 1'b0);
    chk("first_valid", 32'(valid_out), 32'd1);
    chk("first_data", 32'(data8_out), 32'h00);
    step(1'b1, 10'h15A, 8'h5A, 1'b0, 1'b0);
    chk("second_data", 32'(data8_out), 32'h5A);

    // Error tolerance: one error then recovery
    step(1'b1, 10'h000, 8'h33, 1'b0, 1'b1);
    chk("err1_state", 32'(state_out), 32'd3);
    chk("err1_valid", 32'(valid_out), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 10'h274, 8'(8'h10 + i), 1'b0, 1'b0);
    chk("recover_state", 32'(state_out), 32'd2);
    chk("recover_data", 32'(data8_out), 32'h13);

    // Enable gating in SYNC
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 10'h000, 8'hFF, 1'b0, 1'b1);
      chk("gate_state", 32'(state_out), 32'd2);
      chk("gate_valid", 32'(valid_out), 32'd0);
    end

    // Four errors -> LOS
    for (int i = 0; i < 4; i++) step(1'b1, 10'h000, 8'h00, 1'b0, 1'b1);
    chk("los_state", 32'(state_out), 32'd0);
    chk("los_sync_ok", 32'(sync_ok), 32'd0);

    // Acquisition abort needs three fresh commas afterwards
    comma_sym(10'h17C);
    comma_sym(10'h283);
    step(1'b1, 10'h17C, 8'hBC, 1'b1, 1'b1);
    chk("abort_state", 32'(state_out), 32'd0);
    comma_sym(10'h17C);
    comma_sym(10'h283);
    chk("abort_two_state", 32'(state_out), 32'd1);
    comma_sym(10'h17C);
    chk("abort_three_state", 32'(state_out), 32'd2);

    // Asynchronous reset mid-SYNC
    do_reset();
    chk("async_sync_ok", 32'(sync_ok), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [9:0] d10;
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 35) d10 = ($urandom_range(0, 1) != 0) ? 10'h17C : 10'h283;
      else        d10 = 10'($urandom);
      step(1'($urandom_range(0, 99) < 85), d10, 8'($urandom), 1'($urandom),
           1'($urandom_range(0, 99) < 10));
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_sync_ctrl.md
# rx_sync_ctrl

Receive-side synchronization controller for the 8b/10b 10b-to-8b decode path. It watches the 10-bit symbol stream entering `decoder10to8`, acquires symbol sync on K28.5 commas and tracks decode errors to declare loss of sync. It gates the decoder's 8-bit output into a registered `data8_out`/`k_out`/`valid_out` stream for the downstream deserializer logic. `enb` is the symbol strobe, one `clk` cycle per symbol, typically derived from `clk10` of `clks`.

## Interface
- `COMMAS_TO_SYNC`, 3, commas needed to enter SYNC (legal 1..7)
- `ERRS_TO_LOS`, 4, outstanding errors that force loss of sync (legal 2..7)
- `GOOD_TO_RECOVER`, 4, consecutive good symbols that retire one outstanding error (legal 1..7)

- `clk` in 1: single clock; all state updates on rising edge
- `rst` in 1: asynchronous, active-low reset
- `enb` in 1: symbol strobe; one symbol sampled per `clk` with `enb`=1
- `data10_in` in 10: raw symbol, bit order j h g f i e d c b a (bit 9..0)
- `data8_in` in 8: decoder output H..A for the same symbol, same cycle
- `k_in` in 1: decoder control-character flag, same cycle
- `code_err_in` in 1: decoder invalid-code/disparity flag, same cycle
- `data8_out` out 8: forwarded data byte, registered
- `k_out` out 1: forwarded K flag, registered
- `valid_out` out 1: one-cycle qualifier for `data8_out`/`k_out`
- `comma_det` out 1: registered; sampled symbol was K28.5
- `sync_ok` out 1: high in SYNC or CHECK
- `state_out` out 2: current state encoding

## Operation
- Comma is `data10_in` == 10'h17C (K28.5 RD-) or 10'h283 (K28.5 RD+). A symbol with `code_err_in`=1 is never a comma; the error takes priority.
- The block evaluates a symbol only on cycles with `enb`=1. With `enb`=0, all state and counters hold and `valid_out`=0, `comma_det`=0.
- States: LOS=2'd0, ACQ=2'd1, SYNC=2'd2, CHECK=2'd3.
- Counters are 3 bits: `comma_cnt`, `err_cnt`, `good_cnt`. They saturate and never wrap.
- LOS:
  - A comma sets `comma_cnt`=1.
  - If `COMMAS_TO_SYNC`=1 the next state is SYNC; otherwise it is ACQ.
  - Any other symbol stays in LOS with `comma_cnt`=0.
- ACQ:
  - A comma increments `comma_cnt`. When `comma_cnt` reaches `COMMAS_TO_SYNC`, go to SYNC and clear `comma_cnt`.
  - A good non-comma symbol holds.
  - `code_err_in` goes to LOS and clears `comma_cnt`.
- SYNC: `code_err_in` goes to CHECK with `err_cnt`=1 and `good_cnt`=0. Otherwise stay.
- CHECK:
  - Error: `err_cnt`++ and `good_cnt`=0. If the new `err_cnt`==`ERRS_TO_LOS`, go to LOS and clear all counters.
  - Good symbol: `good_cnt`++. When `good_cnt` reaches `GOOD_TO_RECOVER`, `err_cnt`-- and `good_cnt`=0. If `err_cnt` becomes 0, go to SYNC.
- Forwarding uses the state before the update.
  - If the current state is SYNC or CHECK and `code_err_in`=0, then `valid_out`=1, `data8_out`=`data8_in` and `k_out`=`k_in`. Commas are forwarded with `k_out`=1.
  - Otherwise `valid_out`=0, and `data8_out`/`k_out` hold their previous values.
- `sync_ok` and `state_out` are decoded from the state register only; they have no combinational path from the inputs.

## Timing
- Reset (`rst`=0, asynchronous) gives state=LOS, all counters 0, `data8_out`=8'h00, `k_out`=0, `valid_out`=0, `comma_det`=0, `sync_ok`=0, `state_out`=2'd0.
- Reset asserted mid-operation clears everything immediately, with no clock needed. Release is sampled at the next rising `clk`.
- Latency: a symbol sampled at edge N appears on `data8_out`/`k_out`/`valid_out`/`comma_det` after edge N; it is visible during cycle N+1.
- `sync_ok` rises after the edge that samples the `COMMAS_TO_SYNC`-th comma. That comma itself is not forwarded; the first forwarded symbol is the next one.
- `sync_ok` falls after the edge that samples the `ERRS_TO_LOS`-th outstanding error.
- Back-to-back `enb` is supported, one symbol per clock. There is no backpressure.

## Test plan
- **Reset:** `rst`=0 with random inputs → all outputs 0 and `state_out`=0. Assert `rst`=0 asynchronously mid-SYNC → `sync_ok` drops before the next edge.
- **Acquisition:** after reset, feed 10'h17C, 10'h283, then 10'h17C, all with `enb`=1, with `k_in`=1 and `data8_in`=8'hBC on commas → `state_out` goes 1, 1, 2; `sync_ok`=1 after the third edge; `valid_out` stays 0 through the third comma. The next symbol, 10'h274 with `data8_in`=8'h00, gives `valid_out`=1 and `data8_out`=8'h00 one cycle later.
- **Acquisition abort:** two commas, then a symbol with `code_err_in`=1 → `state_out`=0 and `comma_cnt`=0. Three more commas are needed to reach SYNC.
- **Error tolerance:**
  - In SYNC, send 1 error then 4 good symbols → CHECK then back to SYNC; the errored symbol has `valid_out`=0.
  - Send 4 consecutive errors → LOS after the 4th and `sync_ok`=0.
- **Enable gating:** in SYNC, hold `enb`=0 for 5 cycles while driving `code_err_in`=1 → no state change and `valid_out`=0 throughout.
- **Priority:** 10'h17C with `code_err_in`=1 in LOS → not counted as a comma, `comma_det`=0, state stays LOS.
